operand_feeder: RTL and testbench

- Operand source on the other end of the accelerator controller's `data_rdy` / `read_en` interface.
- Loads one operand set of DEPTH words from an upstream valid/ready stream, then asserts `data_rdy_o`.
- After that, it returns one word per `read_en_i` pulse, replaying the buffer in order with wrap-around so every layer pass sees the same sequence.
- Sits between the host/DMA stream and the v_bus/h_bus operand inputs of the MAC array.

---
 rtl/mac_acc_pkg.sv | 14 +
 rtl/operand_feeder_if.sv | 38 +++
 rtl/operand_feeder_mem.sv | 39 +++
 rtl/operand_feeder.sv | 154 +++++++++++++++
 tb/tb_operand_feeder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_acc_pkg.sv
// Shared definitions for the MAC accelerator slice: operand feeder state
// encoding and the default operand geometry used by the MAC array.
package mac_acc_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_DEPTH  = 16;
  localparam int MAC_PASS_W = 3;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    READY = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Operand feeder bus: the upstream load stream plus the controller-side
// data_rdy / read_en read channel. The master is the host/controller side,
// the slave is the feeder.
interface operand_feeder_if
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
);

  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              data_rdy_o;
  logic              read_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    output read_en_i,
    input  in_ready_o,
    input  data_rdy_o,
    input  rd_data_o,
    input  rd_valid_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  read_en_i,
    output in_ready_o,
    output data_rdy_o,
    output rd_data_o,
    output rd_valid_o
  );

endinterface

// File: rtl/operand_feeder_mem.sv
// DEPTH x DATA_W operand buffer with one synchronous write port and one
// synchronous registered read port, shaped so it can map onto a RAM macro.
// Only the read output register is reset; the array itself never is.
module feeder_mem
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int DEPTH  = MAC_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the accepted word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output, holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder: loads one operand set of DEPTH words from the upstream
// stream, then replays it word by word on read_en with wrap-around, counting
// completed passes and flagging reads attempted before the set is loaded.
module operand_feeder
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int DEPTH  = MAC_DEPTH,
  parameter int PASS_W = MAC_PASS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  operand_feeder_if.slave   bus,
  output logic [PASS_W-1:0] pass_cnt_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  feeder_state_t     state;
  feeder_state_t     state_next;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_fire;
  logic              rd_fire;
  logic              rd_refused;
  logic              in_ready;
  logic              data_rdy;
  logic              rd_valid;
  logic [PASS_W-1:0] pass_cnt;
  logic              err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; clear_i suppresses every transfer and
  // forces LOAD, so a write or read coinciding with it is discarded.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    data_rdy   = 1'b0;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    rd_refused = 1'b0;
    case (state)
      LOAD: begin
        in_ready   = 1'b1;
        wr_fire    = bus.in_valid_i && !clear_i;
        // Still loading: a read request here is a protocol error, even on
        // the cycle of the final transfer.
        rd_refused = bus.read_en_i && !clear_i;
        if (wr_fire && (wr_ptr == LAST_PTR)) begin
          state_next = READY;
        end
      end
      READY: begin
        data_rdy = 1'b1;
        rd_fire  = bus.read_en_i && !clear_i;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
    if (clear_i) begin
      state_next = LOAD;
    end
  end

  // Write pointer: advances per accepted word, wraps naturally to 0 after
  // the last word since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer: advances per accepted read, wrapping for the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (clear_i) begin
      rd_ptr <= '0;
    end else if (rd_fire) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Read valid: exactly one cycle after each accepted read, matching the
  // registered read latency of the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
    end
  end

  // Pass counter: bumps when the last word of the set is read, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
    end else if (clear_i) begin
      pass_cnt <= '0;
    end else if (rd_fire && (rd_ptr == LAST_PTR) && (pass_cnt != '1)) begin
      pass_cnt <= pass_cnt + PASS_W'(1);
    end
  end

  // Sticky error: set by a read attempted while loading, cleared only by
  // clear_i or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clear_i) begin
      err <= 1'b0;
    end else if (rd_refused) begin
      err <= 1'b1;
    end
  end

  feeder_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data_i),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (bus.rd_data_o)
  );

  assign bus.in_ready_o = in_ready;
  assign bus.data_rdy_o = data_rdy;
  assign bus.rd_valid_o = rd_valid;
  assign pass_cnt_o     = pass_cnt;
  assign err_o          = err;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: expected read words are queued when a
// read is issued and popped when the feeder returns data.
module tb_operand_feeder;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [2:0] pass_cnt;
  logic       err;

  operand_feeder_if #(.DATA_W(8)) bus ();

  operand_feeder #(
    .DATA_W (8),
    .DEPTH  (16),
    .PASS_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .bus        (bus),
    .pass_cnt_o (pass_cnt),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_mem [16];
  int         m_rd;
  int         m_pass;
  bit         m_ready;
  bit         m_err;
  logic [7:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input bit also_last);
    m_rd    = 0;
    m_pass  = 0;
    m_ready = 0;
    m_err   = 0;
    exp_q.delete();
    if (also_last) m_last = 8'h00;
  endtask

  // One cycle with read_en = en; checks data, valid, pass count and error.
  task automatic rd_cycle(input bit en);
    bus.read_en_i = en;
    if (en && m_ready) begin
      exp_q.push_back(m_mem[m_rd]);
      m_rd = (m_rd + 1) % 16;
      if (m_rd == 0 && m_pass < 7) m_pass++;
    end else if (en) begin
      m_err = 1;
    end
    cyc();
    bus.read_en_i = 1'b0;
    if (exp_q.size() > 0) begin
      m_last = exp_q.pop_front();
      chk("rd_valid", bus.rd_valid_o, 1);
      chk("rd_data", bus.rd_data_o, m_last);
    end else begin
      chk("rd_valid_idle", bus.rd_valid_o, 0);
      chk("rd_data_hold", bus.rd_data_o, m_last);
    end
    chk("pass_cnt", pass_cnt, m_pass);
    chk("err", err, m_err);
  endtask

  // Full 16-word load; optionally raises read_en together with the last word.
  task automatic load16(input logic [7:0] base, input bit rd_last);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = base + 8'(i);
      m_mem[i]       = base + 8'(i);
      chk("in_ready_load", bus.in_ready_o, 1);
      if (i == 15 && rd_last) begin
        bus.read_en_i = 1'b1;
        m_err = 1;
      end
      cyc();
      bus.read_en_i = 1'b0;
      chk("data_rdy_load", bus.data_rdy_o, (i == 15));
      if (i == 15 && rd_last) chk("rd_valid_refused", bus.rd_valid_o, 0);
    end
    bus.in_valid_i = 1'b0;
    m_ready = 1;
    chk("in_ready_full", bus.in_ready_o, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_data_rdy", bus.data_rdy_o, 0);
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    clear          = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    bus.read_en_i  = 1'b0;
    model_reset(1);

    // 1: reset values, then load 0x10..0x1F with valid held high.
    cyc();
    cyc();
    chk_reset_outputs();
    rst_n = 1'b1;
    load16(8'h10, 0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'hEE;
    cyc();
    bus.in_valid_i = 1'b0;
    chk("ready_ignores_valid", bus.in_ready_o, 0);
    chk("ready_holds", bus.data_rdy_o, 1);
    chk("ready_no_err", err, 0);

    // 2: sparse reads, one pulse every other cycle.
    for (int i = 0; i < 16; i++) begin
      rd_cycle(1);
      rd_cycle(0);
    end
    chk("pass_after_first", pass_cnt, 1);

    // 3: back-to-back reads for 8 passes; counter saturates at 7.
    for (int i = 0; i < 128; i++) rd_cycle(1);
    rd_cycle(0);
    chk("pass_saturated", pass_cnt, 7);

    // 4: read before loading sets the sticky error.
    rst_n = 1'b0;
    model_reset(1);
    cyc();
    rst_n = 1'b1;
    rd_cycle(1);
    chk("err_set", err, 1);
    load16(8'h30, 0);
    chk("err_sticky", err, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_reset(0);
    chk("err_cleared", err, 0);

    // 5: clear together with a read at rd_ptr = 5, then reload.
    load16(8'h30, 0);
    for (int i = 0; i < 5; i++) rd_cycle(1);
    clear = 1'b1;
    bus.read_en_i = 1'b1;
    cyc();
    clear = 1'b0;
    bus.read_en_i = 1'b0;
    model_reset(0);
    chk("clr_rd_valid", bus.rd_valid_o, 0);
    chk("clr_data_rdy", bus.data_rdy_o, 0);
    chk("clr_in_ready", bus.in_ready_o, 1);
    chk("clr_pass", pass_cnt, 0);
    load16(8'hA0, 1);
    rd_cycle(1);
    rd_cycle(0);

    // 6: asynchronous reset mid-load after 7 words.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_reset(0);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'h60 + 8'(i);
      cyc();
    end
    bus.in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset(1);
    #1;
    chk_reset_outputs();
    cyc();
    rst_n = 1'b1;
    load16(8'h50, 0);
    rd_cycle(1);
    rd_cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
